// File: rtl/arcade_input_map.sv
`default_nettype none
// ============================================================================
// arcade_input_map: merges PS/2 keys with USB/DB9 joysticks, rotates
// directions and shapes rate-limited coin pulses for active-low core inputs.
// Revision: 1.0
// ============================================================================
module arcade_input_map #(
  parameter int          PLAYERS    = 2,
  parameter int          BUTTONS    = 3,
  parameter logic [15:0] COIN_PULSE = 16'd4096,
  parameter logic [15:0] COIN_GAP   = 16'd8192
) (
  input  logic                       clk_sys,
  input  logic                       I_RESETn,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joy_usb,
  input  logic [16*PLAYERS-1:0]      joy_db9,
  input  logic [PLAYERS-1:0]         src_db9,
  input  logic [1:0]                 rot,
  input  logic                       auto_coin,
  output logic [4*PLAYERS-1:0]       O_DIR_n,
  output logic [BUTTONS*PLAYERS-1:0] O_BTN_n,
  output logic [PLAYERS-1:0]         O_START_n,
  output logic [PLAYERS-1:0]         O_COIN_n
);

  localparam logic [15:0] PULSE_LOAD = COIN_PULSE - 16'd1;
  localparam logic [15:0] GAP_LOAD   = COIN_GAP - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_e;

  // Key latches use the joystick word layout so they can be ORed in directly.
  logic            tog_q, tog_d;
  logic [1:0][9:0] kb_q, kb_d;
  logic            key_hit;
  logic            key_pl;
  logic [3:0]      key_bit;

  always_comb begin
    key_hit = 1'b1;
    key_pl  = 1'b0;
    key_bit = 4'd0;
    casez (ps2_key[8:0])
      9'b?0111_0101: key_bit = 4'd3;
      9'b?0111_0010: key_bit = 4'd2;
      9'b?0110_1011: key_bit = 4'd1;
      9'b?0111_0100: key_bit = 4'd0;
      9'h014:        key_bit = 4'd4;
      9'h011:        key_bit = 4'd5;
      9'h029:        key_bit = 4'd6;
      9'h016, 9'h005: key_bit = 4'd8;
      9'h02E:        key_bit = 4'd9;
      9'h02D: begin key_pl = 1'b1; key_bit = 4'd3; end
      9'h02B: begin key_pl = 1'b1; key_bit = 4'd2; end
      9'h023: begin key_pl = 1'b1; key_bit = 4'd1; end
      9'h034: begin key_pl = 1'b1; key_bit = 4'd0; end
      9'h01C: begin key_pl = 1'b1; key_bit = 4'd4; end
      9'h01B: begin key_pl = 1'b1; key_bit = 4'd5; end
      9'h015: begin key_pl = 1'b1; key_bit = 4'd6; end
      9'h01E, 9'h006: begin key_pl = 1'b1; key_bit = 4'd8; end
      9'h036: begin key_pl = 1'b1; key_bit = 4'd9; end
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    tog_d = ps2_key[10];
    kb_d  = kb_q;
    if ((ps2_key[10] != tog_q) && key_hit) begin
      kb_d[key_pl][key_bit] = ps2_key[9];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!I_RESETn) begin
      tog_q <= ps2_key[10];
      kb_q  <= '0;
    end else begin
      tog_q <= tog_d;
      kb_q  <= kb_d;
    end
  end

  logic unused_kb;
  assign unused_kb = ^kb_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [15:0]        jp;
    logic [9:0]         kb;
    logic [9:0]         raw;
    logic [3:0]         dir_rot;
    logic [3:0]         dir_d, dir_q;
    logic [BUTTONS-1:0] btn_d, btn_q;
    logic               start_d, start_q;
    logic               trig;
    logic               prev_d, prev_q;
    coin_state_e        st_d, st_q;
    logic [15:0]        cnt_d, cnt_q;
    logic               coin_d, coin_q;
    logic               unused_jp;

    assign jp = src_db9[p] ? joy_db9[16*p +: 16] : joy_usb[16*p +: 16];

    if (p < 2) begin : g_kb
      assign kb = kb_q[p];
    end else begin : g_no_kb
      assign kb = '0;
    end

    assign raw       = jp[9:0] | kb;
    assign unused_jp = ^{jp, raw};

    // Each output direction {U,D,L,R} picks one raw direction per rotation.
    always_comb begin
      case (rot)
        2'd1:    dir_rot = {raw[1], raw[0], raw[2], raw[3]};
        2'd2:    dir_rot = {raw[2], raw[3], raw[0], raw[1]};
        2'd3:    dir_rot = {raw[0], raw[1], raw[3], raw[2]};
        default: dir_rot = raw[3:0];
      endcase
    end

    assign dir_d   = ~dir_rot;
    assign btn_d   = ~raw[4 +: BUTTONS];
    assign start_d = ~raw[8];
    assign trig    = raw[9] | (auto_coin & raw[8]);

    always_comb begin
      prev_d = trig;
      st_d   = st_q;
      cnt_d  = cnt_q;
      coin_d = coin_q;
      case (st_q)
        ST_IDLE: begin
          if (trig && !prev_q) begin
            st_d   = ST_PULSE;
            cnt_d  = PULSE_LOAD;
            coin_d = 1'b0;
          end
        end
        ST_PULSE: begin
          if (cnt_q == 16'd0) begin
            coin_d = 1'b1;
            if (COIN_GAP == 16'd0) begin
              st_d = ST_IDLE;
            end else begin
              st_d  = ST_GAP;
              cnt_d = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 16'd0) begin
            st_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          st_d   = ST_IDLE;
          coin_d = 1'b1;
        end
      endcase
    end

    always_ff @(posedge clk_sys) begin
      if (!I_RESETn) begin
        dir_q   <= '1;
        btn_q   <= '1;
        start_q <= 1'b1;
        coin_q  <= 1'b1;
        prev_q  <= 1'b0;
        st_q    <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        dir_q   <= dir_d;
        btn_q   <= btn_d;
        start_q <= start_d;
        coin_q  <= coin_d;
        prev_q  <= prev_d;
        st_q    <= st_d;
        cnt_q   <= cnt_d;
      end
    end

    assign O_DIR_n[4*p +: 4]             = dir_q;
    assign O_BTN_n[BUTTONS*p +: BUTTONS] = btn_q;
    assign O_START_n[p]                  = start_q;
    assign O_COIN_n[p]                   = coin_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_map.sv
`default_nettype none
// Bench for arcade_input_map: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model.
module tb_arcade_input_map;

  localparam int CP = 4;
  localparam int CG = 3;

  logic        clk_sys;
  logic        I_RESETn;
  logic [10:0] ps2_key;
  logic [63:0] joy_usb;
  logic [63:0] joy_db9;
  logic [3:0]  src_db9;
  logic [1:0]  rot;
  logic        auto_coin;
  logic [15:0] O_DIR_n;
  logic [15:0] O_BTN_n;
  logic [3:0]  O_START_n;
  logic [3:0]  O_COIN_n;

  arcade_input_map #(
    .PLAYERS(4), .BUTTONS(4), .COIN_PULSE(16'd4), .COIN_GAP(16'd3)
  ) dut (
    .clk_sys(clk_sys), .I_RESETn(I_RESETn), .ps2_key(ps2_key),
    .joy_usb(joy_usb), .joy_db9(joy_db9), .src_db9(src_db9), .rot(rot),
    .auto_coin(auto_coin), .O_DIR_n(O_DIR_n), .O_BTN_n(O_BTN_n),
    .O_START_n(O_START_n), .O_COIN_n(O_COIN_n)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [8:0] code;
    bit         any_ext;
    int         pl;
    int         idx;
  } key_t;

  key_t ktab[$];

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  bit [9:0]    mkb [2];
  bit          mtog;
  bit          mprev [4];
  int          macc [4];
  int          mfree [4];
  logic [15:0] e_dir, e_btn;
  logic [3:0]  e_start, e_coin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic add_key(input logic [8:0] code, input bit any_ext, input int pl, input int idx);
    key_t k;
    k.code = code; k.any_ext = any_ext; k.pl = pl; k.idx = idx;
    ktab.push_back(k);
  endtask

  // Circular order U,R,D,L (index 0..3) mapped to output bit positions.
  function automatic int dir_bit(input int i);
    case (i)
      0: return 3;
      1: return 0;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic kb_event(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic step();
    logic [15:0] jp;
    logic [9:0]  raw;
    bit          trig;
    if (!I_RESETn) begin
      mkb[0] = '0;
      mkb[1] = '0;
      mtog   = ps2_key[10];
      for (int p = 0; p < 4; p++) begin
        mprev[p] = 1'b0;
        macc[p]  = -100;
        mfree[p] = edge_n + 1;
      end
      e_dir = '1; e_btn = '1; e_start = '1; e_coin = '1;
    end else begin
      for (int p = 0; p < 4; p++) begin
        jp  = src_db9[p] ? joy_db9[16*p +: 16] : joy_usb[16*p +: 16];
        raw = jp[9:0];
        if (p < 2) raw = raw | mkb[p];
        // rotating by r quarter turns: output dir i comes from raw dir (i - r)
        for (int i = 0; i < 4; i++)
          e_dir[4*p + dir_bit(i)] = ~raw[dir_bit((i - int'(rot) + 4) % 4)];
        for (int b = 0; b < 4; b++) e_btn[4*p + b] = ~raw[4 + b];
        e_start[p] = ~raw[8];
        trig = raw[9] | (auto_coin & raw[8]);
        if (trig && !mprev[p] && edge_n >= mfree[p]) begin
          macc[p]  = edge_n;
          mfree[p] = edge_n + CP + CG + 1;
        end
        mprev[p]  = trig;
        e_coin[p] = !(edge_n >= macc[p] && edge_n < macc[p] + CP);
      end
      if (ps2_key[10] != mtog) begin
        mtog = ps2_key[10];
        foreach (ktab[k]) begin
          if (ktab[k].any_ext ? (ktab[k].code[7:0] == ps2_key[7:0]) : (ktab[k].code == ps2_key[8:0]))
            mkb[ktab[k].pl][ktab[k].idx] = ps2_key[9];
        end
      end
    end
    @(posedge clk_sys);
    #1;
    edge_n++;
    check("dir", 32'(O_DIR_n), 32'(e_dir));
    check("btn", 32'(O_BTN_n), 32'(e_btn));
    check("start", 32'(O_START_n), 32'(e_start));
    check("coin", 32'(O_COIN_n), 32'(e_coin));
  endtask

  initial begin
    int low_cnt;
    int pulse_cnt;
    logic last_coin;
    int k;

    add_key(9'h075, 1, 0, 3); add_key(9'h072, 1, 0, 2);
    add_key(9'h06B, 1, 0, 1); add_key(9'h074, 1, 0, 0);
    add_key(9'h014, 0, 0, 4); add_key(9'h011, 0, 0, 5);
    add_key(9'h029, 0, 0, 6); add_key(9'h016, 0, 0, 8);
    add_key(9'h005, 0, 0, 8); add_key(9'h02E, 0, 0, 9);
    add_key(9'h02D, 0, 1, 3); add_key(9'h02B, 0, 1, 2);
    add_key(9'h023, 0, 1, 1); add_key(9'h034, 0, 1, 0);
    add_key(9'h01C, 0, 1, 4); add_key(9'h01B, 0, 1, 5);
    add_key(9'h015, 0, 1, 6); add_key(9'h01E, 0, 1, 8);
    add_key(9'h006, 0, 1, 8); add_key(9'h036, 0, 1, 9);

    I_RESETn = 1'b0; ps2_key = '0; joy_usb = '0; joy_db9 = '0;
    src_db9 = '0; rot = 2'd0; auto_coin = 1'b0;
    repeat (3) step();
    check("reset_outputs", {O_DIR_n, O_BTN_n}, 32'hFFFF_FFFF);
    I_RESETn = 1'b1;
    repeat (2) step();

    // Keyboard: extended up arrow
    kb_event(1'b1, 9'h175);
    step(); step();
    check("kb_p1_up_press", 32'(O_DIR_n[3]), 32'd0);
    kb_event(1'b0, 9'h175);
    step(); step();
    check("kb_p1_up_release", 32'(O_DIR_n[3]), 32'd1);

    // Rotation
    rot = 2'd1; joy_usb[1] = 1'b1;
    step();
    check("rot1_left", 32'(O_DIR_n[3:0]), 32'(4'b0111));
    rot = 2'd3;
    step();
    check("rot3_left", 32'(O_DIR_n[3:0]), 32'(4'b1011));
    joy_usb = '0; rot = 2'd0;
    step();

    // Held coin key: one pulse of exactly CP cycles
    kb_event(1'b1, 9'h02E);
    low_cnt = 0; pulse_cnt = 0; last_coin = 1'b1;
    repeat (20) begin
      step();
      if (!O_COIN_n[0]) low_cnt++;
      if (last_coin && !O_COIN_n[0]) pulse_cnt++;
      last_coin = O_COIN_n[0];
    end
    check("coin_low_cycles", 32'(low_cnt), 32'd4);
    check("coin_pulse_count", 32'(pulse_cnt), 32'd1);
    kb_event(1'b0, 9'h02E);
    repeat (3) step();

    // Press during gap is discarded, press after gap is accepted
    joy_usb[9] = 1'b1; step();
    joy_usb[9] = 1'b0; repeat (4) step();
    joy_usb[9] = 1'b1; step();
    check("coin_gap_discard", 32'(O_COIN_n[0]), 32'd1);
    joy_usb[9] = 1'b0; step(); step();
    joy_usb[9] = 1'b1; step();
    check("coin_after_gap", 32'(O_COIN_n[0]), 32'd0);
    joy_usb[9] = 1'b0;
    repeat (8) step();

    // Auto coin from DB9 start on slot 1
    auto_coin = 1'b1; src_db9[1] = 1'b1; joy_db9[24] = 1'b1;
    step();
    check("auto_start1", 32'(O_START_n[1]), 32'd0);
    check("auto_coin1", 32'(O_COIN_n[1]), 32'd0);
    low_cnt = 1;
    repeat (8) begin
      step();
      if (!O_COIN_n[1]) low_cnt++;
    end
    check("auto_coin1_low", 32'(low_cnt), 32'd4);
    check("auto_coin0_idle", 32'(O_COIN_n[0]), 32'd1);
    joy_db9 = '0; src_db9 = '0; auto_coin = 1'b0;
    repeat (8) step();

    // Reset mid pulse with keys latched
    kb_event(1'b1, 9'h075); step();
    kb_event(1'b1, 9'h014); step();
    joy_usb[9] = 1'b1; step();
    joy_usb[9] = 1'b0; step();
    I_RESETn = 1'b0;
    step();
    check("reset_mid_pulse", {O_DIR_n, O_BTN_n}, 32'hFFFF_FFFF);
    check("reset_mid_pulse_coin", 32'({O_START_n, O_COIN_n}), 32'h0000_00FF);
    I_RESETn = 1'b1;
    repeat (10) step();
    check("post_reset_no_key", 32'(O_DIR_n[3]), 32'd1);
    check("post_reset_no_coin", 32'(O_COIN_n), 32'hF);

    // P4 button 3 from USB; keyboard cannot reach P3/P4
    joy_usb[55] = 1'b1;
    step();
    check("p4_btn3", 32'(O_BTN_n[15]), 32'd0);
    joy_usb = '0;
    foreach (ktab[i]) begin
      kb_event(1'b1, ktab[i].code);
      step();
    end
    step();
    check("kb_no_p34_dir", 32'(O_DIR_n[15:8]), 32'hFF);
    check("kb_no_p34_btn", 32'(O_BTN_n[15:8]), 32'hFF);
    check("kb_no_p34_start", 32'(O_START_n[3:2]), 32'h3);
    foreach (ktab[i]) begin
      kb_event(1'b0, ktab[i].code);
      step();
    end

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      I_RESETn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, ktab.size() - 1);
        if ($urandom_range(0, 4) == 0)
          kb_event(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
        else
          kb_event(1'($urandom_range(0, 1)), ktab[k].code | {($urandom_range(0, 1) == 1) & ktab[k].any_ext, 8'h00});
      end else if ($urandom_range(0, 7) == 0) begin
        ps2_key[9] = ~ps2_key[9];
      end
      if ($urandom_range(0, 3) == 0) joy_usb = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) joy_db9 = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) src_db9 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rot = 2'($urandom);
      if ($urandom_range(0, 15) == 0) auto_coin = ~auto_coin;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
